scan_chain: RTL and testbench

//  Serial scan-chain access block: a 25-bit two-phase (master/slave) shift chain

---
 rtl/scan_chain_if.sv | 20 ++
 rtl/scan_chain.sv | 133 +++++++++++++
 tb/tb_scan_chain.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_if.sv
// Pad-side scan pins of the scan chain: five pad inputs into the block and serial data out.
// The master modport drives the pads; the slave modport belongs to the chain itself.
interface scan_chain_if;
  logic scan_phi;
  logic scan_phi_bar;
  logic scan_data_in;
  logic scan_data_out;
  logic scan_load_chip;
  logic scan_load_chain;

  modport master (
    output scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain,
    input  scan_data_out
  );

  modport slave (
    input  scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain,
    output scan_data_out
  );
endinterface

// File: rtl/scan_chain.sv
// 25-bit two-phase scan chain bridging pad strobes to chip control/status registers.
// Strobe actions land SYNC_STAGES+1 clk after a pad edge; pads are level-held, so there is no backpressure.
module scan_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  scan_chain_if.slave sif,
  output logic        scan_reset,
  output logic        write_data_1,
  output logic [1:0]  write_data_2,
  output logic [2:0]  write_data_3,
  output logic [15:0] write_data_array,
  input  logic        read_data_1,
  input  logic [1:0]  read_data_2,
  input  logic [2:0]  read_data_3,
  input  logic [15:0] read_data_array
);

  localparam int P_PHI    = 0;
  localparam int P_PHIB   = 1;
  localparam int P_DIN    = 2;
  localparam int P_LCHIP  = 3;
  localparam int P_LCHAIN = 4;

  logic [4:0]                   pin_raw;
  logic [SYNC_STAGES-1:0][4:0]  sync_q, sync_d;
  logic [4:0]                   pin_s;
  logic [4:0]                   prev_q, prev_d;
  logic [4:0]                   rise;

  logic [24:0] master_q, master_d;
  logic [24:0] slave_q, slave_d;
  logic        scan_reset_q, scan_reset_d;
  logic        wd1_q, wd1_d;
  logic [1:0]  wd2_q, wd2_d;
  logic [2:0]  wd3_q, wd3_d;
  logic [15:0] wda_q, wda_d;

  assign pin_raw = {sif.scan_load_chain, sif.scan_load_chip, sif.scan_data_in,
                    sif.scan_phi_bar, sif.scan_phi};

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = pin_raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    pin_s  = sync_q[SYNC_STAGES-1];
    prev_d = pin_s;
    rise   = pin_s & ~prev_q;
  end

  always_comb begin
    master_d     = master_q;
    slave_d      = slave_q;
    scan_reset_d = scan_reset_q;
    wd1_d        = wd1_q;
    wd2_d        = wd2_q;
    wd3_d        = wd3_q;
    wda_d        = wda_q;

    if (rise[P_PHI]) begin
      if (pin_s[P_LCHAIN]) begin
        // Parallel capture: address fields keep their chain value and steer the array muxes.
        master_d        = slave_q;
        master_d[0]     = scan_reset_q;
        master_d[1]     = wd1_q;
        master_d[3:2]   = wd2_q;
        master_d[6:4]   = wd3_q;
        master_d[12:9]  = wda_q[{slave_q[8:7], 2'b00} +: 4];
        master_d[13]    = read_data_1;
        master_d[15:14] = read_data_2;
        master_d[18:16] = read_data_3;
        master_d[24:21] = read_data_array[{slave_q[20:19], 2'b00} +: 4];
      end else begin
        master_d = {pin_s[P_DIN], slave_q[24:1]};
      end
    end

    // Uses master_q, so a coincident phi edge is not seen by the slave this cycle.
    if (rise[P_PHIB]) begin
      slave_d = master_q;
    end

    if (rise[P_LCHIP]) begin
      scan_reset_d = slave_q[0];
      if (slave_q[0]) begin
        wd1_d = 1'b0;
        wd2_d = 2'b0;
        wd3_d = 3'b0;
        wda_d = 16'h0;
      end else begin
        wd1_d = slave_q[1];
        wd2_d = slave_q[3:2];
        wd3_d = slave_q[6:4];
        wda_d[{slave_q[8:7], 2'b00} +: 4] = slave_q[12:9];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= '0;
      prev_q       <= '0;
      master_q     <= '0;
      slave_q      <= '0;
      scan_reset_q <= 1'b0;
      wd1_q        <= 1'b0;
      wd2_q        <= 2'b0;
      wd3_q        <= 3'b0;
      wda_q        <= 16'h0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      master_q     <= master_d;
      slave_q      <= slave_d;
      scan_reset_q <= scan_reset_d;
      wd1_q        <= wd1_d;
      wd2_q        <= wd2_d;
      wd3_q        <= wd3_d;
      wda_q        <= wda_d;
    end
  end

  assign sif.scan_data_out = slave_q[0];
  assign scan_reset        = scan_reset_q;
  assign write_data_1      = wd1_q;
  assign write_data_2      = wd2_q;
  assign write_data_3      = wd3_q;
  assign write_data_array  = wda_q;

endmodule

// File: tb/tb_scan_chain.sv
// Bench for scan_chain: table of write transactions, hand sequences, and random traffic vs a chain-level model.
module tb_scan_chain;
  localparam int HOLD = 5;

  logic        clk;
  logic        reset_n;
  logic        scan_reset;
  logic        write_data_1;
  logic [1:0]  write_data_2;
  logic [2:0]  write_data_3;
  logic [15:0] write_data_array;
  logic        read_data_1;
  logic [1:0]  read_data_2;
  logic [2:0]  read_data_3;
  logic [15:0] read_data_array;

  scan_chain_if sif ();

  scan_chain #(.SYNC_STAGES(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sif              (sif.slave),
    .scan_reset       (scan_reset),
    .write_data_1     (write_data_1),
    .write_data_2     (write_data_2),
    .write_data_3     (write_data_3),
    .write_data_array (write_data_array),
    .read_data_1      (read_data_1),
    .read_data_2      (read_data_2),
    .read_data_3      (read_data_3),
    .read_data_array  (read_data_array)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_pass  = 0;
  int n_total = 0;

  // Chain-level model: a rotate swaps the chain contents for the shifted-in word.
  logic [24:0] m_chain;
  logic        m_rst;
  logic        m_wd1;
  logic [1:0]  m_wd2;
  logic [2:0]  m_wd3;
  logic [3:0]  m_arr [4];

  typedef struct {
    logic        rst;
    logic        wd1;
    logic [1:0]  wd2;
    logic [2:0]  wd3;
    logic [1:0]  addr;
    logic [3:0]  dat;
    logic        e_rst;
    logic        e_wd1;
    logic [1:0]  e_wd2;
    logic [2:0]  e_wd3;
    logic [15:0] e_arr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [24:0] pack(input logic rst, input logic wd1, input logic [1:0] wd2,
                                       input logic [2:0] wd3, input logic [1:0] waddr,
                                       input logic [3:0] wdat, input logic [1:0] raddr);
    return {4'h0, raddr, 3'h0, 2'h0, 1'b0, wdat, waddr, wd3, wd2, wd1, rst};
  endfunction

  function automatic logic [15:0] m_arr_flat();
    return {m_arr[3], m_arr[2], m_arr[1], m_arr[0]};
  endfunction

  task automatic model_reset();
    m_chain = '0;
    m_rst = 1'b0; m_wd1 = 1'b0; m_wd2 = '0; m_wd3 = '0;
    for (int k = 0; k < 4; k++) m_arr[k] = 4'h0;
  endtask

  task automatic model_load_chip();
    m_rst = m_chain[0];
    if (m_rst) begin
      m_wd1 = 1'b0; m_wd2 = '0; m_wd3 = '0;
      for (int k = 0; k < 4; k++) m_arr[k] = 4'h0;
    end else begin
      m_wd1 = m_chain[1];
      m_wd2 = m_chain[3:2];
      m_wd3 = m_chain[6:4];
      m_arr[m_chain[8:7]] = m_chain[12:9];
    end
  endtask

  task automatic model_load_chain();
    int ridx;
    logic [15:0] rsh;
    ridx = int'(m_chain[20:19]);
    rsh  = read_data_array >> (4 * ridx);
    m_chain[0]     = m_rst;
    m_chain[1]     = m_wd1;
    m_chain[3:2]   = m_wd2;
    m_chain[6:4]   = m_wd3;
    m_chain[12:9]  = m_arr[m_chain[8:7]];
    m_chain[13]    = read_data_1;
    m_chain[15:14] = read_data_2;
    m_chain[18:16] = read_data_3;
    m_chain[24:21] = rsh[3:0];
  endtask

  task automatic hold();
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic pair(input logic din, output logic dout);
    dout = sif.scan_data_out;
    sif.scan_data_in = din;
    hold();
    sif.scan_phi = 1'b1;     hold();
    sif.scan_phi = 1'b0;     hold();
    sif.scan_phi_bar = 1'b1; hold();
    sif.scan_phi_bar = 1'b0; hold();
  endtask

  task automatic rotate(input logic [24:0] vin, output logic [24:0] vout);
    logic b;
    for (int i = 0; i < 25; i++) begin
      pair(vin[i], b);
      vout[i] = b;
    end
  endtask

  task automatic load_chip();
    sif.scan_load_chip = 1'b1; hold();
    sif.scan_load_chip = 1'b0; hold();
  endtask

  task automatic load_chain();
    sif.scan_load_chain = 1'b1; hold();
    sif.scan_phi = 1'b1;        hold();
    sif.scan_phi = 1'b0;        hold();
    sif.scan_load_chain = 1'b0; hold();
    sif.scan_phi_bar = 1'b1;    hold();
    sif.scan_phi_bar = 1'b0;    hold();
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " scan_reset"}, 32'(scan_reset), 32'(m_rst));
    check({tag, " wd1"}, 32'(write_data_1), 32'(m_wd1));
    check({tag, " wd2"}, 32'(write_data_2), 32'(m_wd2));
    check({tag, " wd3"}, 32'(write_data_3), 32'(m_wd3));
    check({tag, " wd_array"}, 32'(write_data_array), 32'(m_arr_flat()));
  endtask

  initial begin
    logic [24:0] vout;
    logic [24:0] vin;
    logic        b;
    int          op;

    vecs[0] = '{1'b1, 1'b1, 2'd3, 3'd7, 2'd1, 4'hF, 1'b1, 1'b0, 2'd0, 3'd0, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 2'd2, 3'd3, 2'd2, 4'hA, 1'b0, 1'b1, 2'd2, 3'd3, 16'h0A00};
    vecs[2] = '{1'b0, 1'b0, 2'd1, 3'd5, 2'd0, 4'h5, 1'b0, 1'b0, 2'd1, 3'd5, 16'h0A05};
    vecs[3] = '{1'b0, 1'b1, 2'd0, 3'd6, 2'd3, 4'hF, 1'b0, 1'b1, 2'd0, 3'd6, 16'hFA05};
    vecs[4] = '{1'b1, 1'b0, 2'd2, 3'd1, 2'd0, 4'h3, 1'b1, 1'b0, 2'd0, 3'd0, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 4'h5, 1'b0, 1'b0, 2'd0, 3'd0, 16'h0005};
    vecs[6] = '{1'b0, 1'b1, 2'd3, 3'd7, 2'd3, 4'hF, 1'b0, 1'b1, 2'd3, 3'd7, 16'hF005};

    reset_n = 1'b0;
    sif.scan_phi = 1'b0; sif.scan_phi_bar = 1'b0; sif.scan_data_in = 1'b0;
    sif.scan_load_chip = 1'b0; sif.scan_load_chain = 1'b0;
    read_data_1 = 1'b0; read_data_2 = '0; read_data_3 = '0; read_data_array = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset data_out", 32'(sif.scan_data_out), 32'd0);
    check("reset wd_array", 32'(write_data_array), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs("post-reset");

    for (int v = 0; v < 7; v++) begin
      vin = pack(vecs[v].rst, vecs[v].wd1, vecs[v].wd2, vecs[v].wd3,
                 vecs[v].addr, vecs[v].dat, 2'd0);
      rotate(vin, vout);
      check($sformatf("vec%0d shift_out", v), 32'(vout), 32'(m_chain));
      m_chain = vin;
      load_chip();
      model_load_chip();
      check($sformatf("vec%0d scan_reset", v), 32'(scan_reset), 32'(vecs[v].e_rst));
      check($sformatf("vec%0d wd1", v), 32'(write_data_1), 32'(vecs[v].e_wd1));
      check($sformatf("vec%0d wd2", v), 32'(write_data_2), 32'(vecs[v].e_wd2));
      check($sformatf("vec%0d wd3", v), 32'(write_data_3), 32'(vecs[v].e_wd3));
      check($sformatf("vec%0d wd_array", v), 32'(write_data_array), 32'(vecs[v].e_arr));
    end

    // Bypass: a second rotate returns the first pattern untouched.
    rotate(25'h1A5C3E6, vout);
    check("bypass first", 32'(vout), 32'(m_chain));
    rotate(25'h0F0F0F1, vout);
    check("bypass second", 32'(vout), 32'h1A5C3E6);
    m_chain = 25'h0F0F0F1;
    check_outputs("bypass");

    // Readback of status through a parallel capture.
    read_data_1 = 1'b0; read_data_2 = 2'd3; read_data_3 = 3'd5; read_data_array = 16'hABCD;
    vin = pack(1'b0, 1'b0, 2'd0, 3'd0, 2'd3, 4'h0, 2'd1);
    rotate(vin, vout);
    check("read pre-rotate", 32'(vout), 32'(m_chain));
    m_chain = vin;
    load_chain();
    model_load_chain();
    rotate(25'h1FFFFFF, vout);
    check("read chain", 32'(vout), 32'(m_chain));
    check("read wd fields", 32'(vout[6:0]), 32'h7E);
    check("read wr_arr data", 32'(vout[12:9]), 32'hF);
    check("read rd fields", 32'(vout[18:13]), 32'(6'b101110));
    check("read rd_arr data", 32'(vout[24:21]), 32'hC);
    m_chain = 25'h1FFFFFF;
    check_outputs("read no-load");

    // Asynchronous reset in the middle of a rotate.
    for (int i = 0; i < 10; i++) pair(1'b1, b);
    check("mid-rotate data_out", 32'(sif.scan_data_out), 32'd1);
    reset_n = 1'b0;
    #1;
    check("areset data_out", 32'(sif.scan_data_out), 32'd0);
    check("areset scan_reset", 32'(scan_reset), 32'd0);
    check("areset wd1", 32'(write_data_1), 32'd0);
    check("areset wd3", 32'(write_data_3), 32'd0);
    check("areset wd_array", 32'(write_data_array), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int it = 0; it < 14; it++) begin
      vin = 25'($urandom);
      vin[0] = ($urandom_range(0, 3) == 0);
      rotate(vin, vout);
      check($sformatf("rand%0d shift_out", it), 32'(vout), 32'(m_chain));
      m_chain = vin;
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        load_chip();
        model_load_chip();
        check_outputs($sformatf("rand%0d", it));
      end else if (op == 1) begin
        read_data_1 = 1'($urandom);
        read_data_2 = 2'($urandom);
        read_data_3 = 3'($urandom);
        read_data_array = 16'($urandom);
        hold();
        load_chain();
        model_load_chain();
      end
    end
    rotate(25'h0, vout);
    check("final shift_out", 32'(vout), 32'(m_chain));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
